// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding and default payload width for the
//               inter-stage pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/en_reg.sv
`default_nettype none
// ============================================================================
// Module      : en_reg
// Description : WIDTH-bit register with async active-low reset, synchronous
//               clear (dominant over load) and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module en_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : en_reg
`default_nettype wire

// File: rtl/stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : stage_skid_reg
// Description : Two-entry valid/ready skid register between pipeline stages;
//               fully registered handshake, full throughput, sync flush.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_acc;
    logic             w_pop;
    logic             w_main_ld;
    logic             w_skid_ld;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_q;

    // Handshake outputs depend only on r_state, never on the opposite side.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign level     = r_state;

    assign w_acc = in_valid & in_ready;
    assign w_pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_skid_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_main_ld   = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_pop) begin
                        w_main_ld = 1'b1;
                    end else if (w_acc) begin
                        w_skid_ld   = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_main_ld        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    en_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_main_ld),
        .i_d   (w_main_d),
        .o_q   (out_data)
    );

    en_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_skid_ld),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

endmodule : stage_skid_reg
`default_nettype wire

// File: tb/tb_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_skid_reg
// Description : Self-checking bench for stage_skid_reg against a queue-based
//               two-slot FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   level;

    logic [W-1:0] mq[$];
    bit           zero_known;
    int           total = 0;
    int           bad   = 0;
    int           delivered = 0;

    always #5 clk = ~clk;

    stage_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":in_ready"},  W'(in_ready),  W'(mq.size() < 2));
        chk({ph, ":out_valid"}, W'(out_valid), W'(mq.size() > 0));
        chk({ph, ":level"},     W'(level),     W'(mq.size()));
        if (mq.size() > 0)
            chk({ph, ":out_data"}, out_data, mq[0]);
        else if (zero_known)
            chk({ph, ":out_data_zero"}, out_data, '0);
    endtask

    // Reference: bounded FIFO of depth 2; pop frees a slot only next cycle.
    task automatic cycle(input string ph);
        bit acc, pop;
        acc = in_valid && (mq.size() < 2);
        pop = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            zero_known = 1'b1;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                delivered++;
            end
            if (acc) begin
                mq.push_back(in_data);
                zero_known = 1'b0;
            end
        end
        #1;
        check_all(ph);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        zero_known = 1'b1;
        #3;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_all("reset_release");

        // Fill to TWO, then reset between edges
        drive(1'b1, 32'hA, 1'b0, 1'b0); cycle("fill_a");
        drive(1'b1, 32'hB, 1'b0, 1'b0); cycle("fill_b");
        chk("fill_level2", W'(level), W'(2));
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        mq.delete();
        zero_known = 1'b1;
        #1;
        check_all("midreset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_all("midreset_rel");
        drive(1'b1, 32'hC, 1'b0, 1'b0); cycle("after_rst_c");
        drive(1'b0, '0, 1'b1, 1'b0);    cycle("drain_c");

        // Streaming, one word per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            cycle("stream");
        end
        drive(1'b0, '0, 1'b1, 1'b0); cycle("stream_drain");

        // Backpressure into the skid slot
        drive(1'b1, 32'h10, 1'b0, 1'b0); cycle("bp_10");
        drive(1'b1, 32'h11, 1'b0, 1'b0); cycle("bp_11");
        drive(1'b1, 32'h12, 1'b0, 1'b0); cycle("bp_12_held");
        cycle("bp_stall");
        chk("bp_in_ready0", W'(in_ready), W'(0));
        drive(1'b1, 32'h12, 1'b1, 1'b0); cycle("bp_pop10");
        cycle("bp_pop11_acc12");
        drive(1'b0, '0, 1'b1, 1'b0);     cycle("bp_pop12");

        // Flush with a simultaneous offer
        drive(1'b1, 32'h20, 1'b0, 1'b0); cycle("fl_20");
        drive(1'b1, 32'h21, 1'b0, 1'b1); cycle("fl_flush");
        drive(1'b0, '0, 1'b1, 1'b0);     cycle("fl_idle1");
        cycle("fl_idle2");

        // Pop and accept together while holding one word
        drive(1'b1, 32'h30, 1'b0, 1'b0); cycle("pa_30");
        drive(1'b1, 32'h31, 1'b1, 1'b0); cycle("pa_31");
        chk("pa_data31", out_data, 32'h31);
        drive(1'b0, '0, 1'b1, 1'b0);     cycle("pa_drain");

        // Random valid/ready with rare flushes
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
            cycle("rand");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("final_drain1");
        cycle("final_drain2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_stage_skid_reg
`default_nettype wire

// File: doc/stage_skid_reg.md
Name: stage_skid_reg

Overview:
Two-entry valid/ready pipeline register that sits between MIPS pipeline stages (IF->ID, ID->EX, ...). It is the receiving end of a stage's output handshake and the sending end of the next stage's input handshake. It breaks every combinational path between the two sides (ready and valid are both registered-state derived) while sustaining one transfer per cycle. Synchronous flush supports branch/jump squash.

Parameters:
WIDTH, 32, bits of payload (instruction word, PC, or packed control bundle)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash; empties the register this edge
in_valid  in  1  upstream stage presents in_data
in_ready  out  1  register can accept this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  out_data holds a valid entry
out_ready  in  1  downstream stage consumes this cycle
out_data  out  WIDTH  oldest held entry
level  out  2  occupancy, 0..2

Behaviour:
- Storage: main register (drives out_data) and skid register, each WIDTH bits; state EMPTY/ONE/TWO.
- Outputs are pure functions of state: in_ready = (state != TWO); out_valid = (state != EMPTY); level = 0/1/2 for EMPTY/ONE/TWO. No combinational path from in_* to out_* or from out_ready to in_ready.
- acc = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: acc -> main <= in_data, ONE. Otherwise stay.
- ONE: acc & pop -> main <= in_data, stay ONE; acc & !pop -> skid <= in_data, TWO; !acc & pop -> EMPTY; neither -> hold.
- TWO: in_ready = 0, so acc is impossible. pop -> main <= skid, ONE; else hold.
- Latency: a word accepted at edge N is on out_data with out_valid = 1 after edge N. Throughput: 1 word/cycle when out_ready is held high.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Data stability: while out_valid = 1 and out_ready = 0, out_data and out_valid must not change (except by flush or reset).
- flush: highest synchronous priority. Next state is EMPTY regardless of acc/pop, and a word offered in the same cycle is dropped. Main and skid registers are cleared to 0.
- Reset (rst_n = 0, asynchronous, including mid-transfer): state EMPTY, main = 0, skid = 0. Therefore out_valid = 0, out_data = 0, in_ready = 1, level = 0, effective immediately without waiting for clk. On release, the first edge may accept.
- in_valid and in_data are don't-care when in_ready = 0. out_ready is don't-care when out_valid = 0.
- Upstream is not required to hold in_valid while in_ready = 0. The block never relies on it.

Decomposition:
- Shared package `pipe_pkg`: state encoding constants ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2, and the default WIDTH constant PIPE_W = 32.
- One natural sub-module: `en_reg` (WIDTH-bit register with async active-low reset, synchronous clear, load enable), instantiated twice for main and skid. The control FSM lives in stage_skid_reg.

Test Plan:
- Reset mid-transfer: fill to TWO with 0xA, 0xB, then pull rst_n low between edges -> out_valid = 0, in_ready = 1, level = 0, out_data = 0 immediately. After release, 0xC is accepted and appears next cycle.
- Streaming: out_ready = 1, in_valid = 1 with 0x1..0x8 on consecutive cycles -> out_data = 0x1..0x8 on consecutive cycles, each one cycle after acceptance. level stays 1. No bubbles.
- Backpressure/skid: out_ready = 0, offer 0x10, 0x11, 0x12 -> 0x10 and 0x11 accepted, level = 2, in_ready = 0, 0x12 held off. Raise out_ready -> outputs 0x10, 0x11, 0x12 in order, with out_data stable during the stall.
- Flush with simultaneous accept: state ONE holding 0x20, assert flush with in_valid = 1 and in_data = 0x21 -> next cycle out_valid = 0, level = 0, and 0x21 never appears.
- Random valid/ready: 1000 cycles of random in_valid/out_ready -> scoreboard shows in-order, lossless, duplicate-free delivery. in_ready = 0 only when level = 2.
- Pop and accept in ONE: hold 0x30, out_ready = 1, in 0x31 -> next cycle out_data = 0x31, level = 1.
